// File: rtl/axi_lite_arb_pkg.sv
// rtl/axi_lite_arb_pkg.sv - shared types and constants for the AXI-Lite master arbiter
package axi_lite_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD,
      RD_RESP,
      RSP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, search starts one past the last grant
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand_idx;
   logic             found;
   int               cand;

   // ptr holds the highest-priority requester for the next search
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand     = (int'(ptr) + i) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found           = 1'b1;
            grant_idx       = cand_idx;
            grant[cand_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// rtl/axi_lite_master_arbiter.sv - shares one AXI4-Lite master port among NUM_REQ requesters
module axi_lite_master_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0]              req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic [ADDR_WIDTH-1:0]           M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]           M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]           M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]           M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t                 state, state_nxt;
   logic [NUM_REQ-1:0]     grant;
   logic [IDX_W-1:0]       grant_idx, grant_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;
   logic [1:0]             resp_q;
   logic                   awvalid_q, wvalid_q, arvalid_q;
   logic                   take, sel_we, aw_done, w_done;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .req       (req_valid),
      .advance   (take),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // gated by ARESET so req_ready stays low while reset is held in IDLE
   assign take    = (state == IDLE) && (|req_valid) && !ARESET;
   assign sel_we  = req_we[grant_idx];
   assign aw_done = !awvalid_q || M_AXI_AWREADY;
   assign w_done  = !wvalid_q || M_AXI_WREADY;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      req_ready    = '0;
      rsp_valid    = '0;
      M_AXI_BREADY = 1'b0;
      M_AXI_RREADY = 1'b0;
      case (state)
         IDLE: begin
            if (take) begin
               req_ready = grant;
               state_nxt = sel_we ? WR : RD;
            end
         end
         WR: begin
            if (aw_done && w_done) state_nxt = WR_RESP;
         end
         WR_RESP: begin
            M_AXI_BREADY = 1'b1;
            if (M_AXI_BVALID) state_nxt = RSP;
         end
         RD: begin
            if (M_AXI_ARREADY) state_nxt = RD_RESP;
         end
         RD_RESP: begin
            M_AXI_RREADY = 1'b1;
            if (M_AXI_RVALID) state_nxt = RSP;
         end
         RSP: begin
            rsp_valid[grant_q] = 1'b1;
            state_nxt          = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // AW and W drop independently, each on its own handshake
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         grant_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= RESP_OKAY;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
      end else begin
         if (take) begin
            grant_q   <= grant_idx;
            addr_q    <= req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q   <= req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            awvalid_q <= sel_we;
            wvalid_q  <= sel_we;
            arvalid_q <= !sel_we;
         end else begin
            if (M_AXI_AWREADY) awvalid_q <= 1'b0;
            if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
            if (M_AXI_ARREADY) arvalid_q <= 1'b0;
         end
         if (state == WR_RESP && M_AXI_BVALID) resp_q <= M_AXI_BRESP;
         if (state == RD_RESP && M_AXI_RVALID) begin
            rdata_q <= M_AXI_RDATA;
            resp_q  <= M_AXI_RRESP;
         end
      end
   end

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_AWPROT  = PROT_DEFAULT;
   assign M_AXI_ARPROT  = PROT_DEFAULT;
   assign M_AXI_WSTRB   = '1;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb/tb_axi_lite_master_arbiter.sv - randomized self-checking bench for axi_lite_master_arbiter
module tb_axi_lite_master_arbiter;
   import axi_lite_arb_pkg::*;

   localparam int N  = 3;
   localparam int AW = 4;
   localparam int DW = 32;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [DW-1:0]     rsp_rdata;
   logic [1:0]        rsp_resp;
   logic [AW-1:0]     M_AXI_AWADDR, M_AXI_ARADDR;
   logic [2:0]        M_AXI_AWPROT, M_AXI_ARPROT;
   logic              M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [DW-1:0]     M_AXI_WDATA, M_AXI_RDATA;
   logic [DW/8-1:0]   M_AXI_WSTRB;
   logic [1:0]        M_AXI_BRESP, M_AXI_RRESP;
   logic              M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic              M_AXI_RVALID, M_AXI_RREADY;

   axi_lite_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // requester side
   bit            pend     [N];
   bit            op_we    [N];
   logic [AW-1:0] op_addr  [N];
   logic [DW-1:0] op_wdata [N];

   // transaction-level reference: one whole transfer at a time
   int            last_grant, cyc, grant_cyc, cur_idx;
   bit            busy, cur_we, rsp_due;
   bit            aw_exp, w_exp, ar_exp, b_exp, r_exp, aw_done, w_done;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata, cur_rdata_exp, last_rdata;
   logic [1:0]    cur_resp;
   logic [DW-1:0] ref_mem [4];

   // behavioural 4-register slave
   logic [DW-1:0] slv_mem [4];
   logic [AW-1:0] slv_awaddr;
   logic [DW-1:0] slv_wdata, slv_rdata;
   bit            slv_aw, slv_w, slv_b_pend, slv_r_pend;
   int            slv_b_cnt, slv_r_cnt;
   logic [1:0]    inj_resp;

   bit issuing, rdy_random, allow_drop, lat_chk, hold_r;
   int req_pct, delay_fix;

   function automatic int pick_delay();
      return (delay_fix >= 0) ? delay_fix : int'($urandom_range(0, 3));
   endfunction

   function automatic bit any_pend();
      bit a = 1'b0;
      for (int i = 0; i < N; i++) a |= pend[i];
      return a;
   endfunction

   task automatic model_reset();
      last_grant = N - 1;
      busy = 0; rsp_due = 0; aw_exp = 0; w_exp = 0; ar_exp = 0; b_exp = 0; r_exp = 0;
      aw_done = 0; w_done = 0; last_rdata = '0; inj_resp = RESP_OKAY;
      slv_aw = 0; slv_w = 0; slv_b_pend = 0; slv_r_pend = 0;
      for (int i = 0; i < 4; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
      for (int i = 0; i < N; i++) pend[i] = 0;
   endtask

   task automatic step();
      logic [N-1:0] exp_ready;
      logic [DW-1:0] exp_rd;
      int win;
      bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
      @(negedge ACLK);
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (pend[i] && allow_drop && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
         else if (!pend[i] && issuing && $urandom_range(0, 99) < req_pct) begin
            pend[i]     = 1'b1;
            op_we[i]    = 1'($urandom_range(0, 1));
            op_addr[i]  = AW'($urandom_range(0, 3) * 4);
            op_wdata[i] = $urandom;
         end
         req_valid[i]            = pend[i];
         req_we[i]               = op_we[i];
         req_addr[i*AW +: AW]    = op_addr[i];
         req_wdata[i*DW +: DW]   = op_wdata[i];
      end
      M_AXI_AWREADY = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXI_WREADY  = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXI_ARREADY = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXI_BVALID  = 1'b0;
      M_AXI_BRESP   = 2'($urandom_range(0, 3));
      if (slv_b_pend) begin
         if (slv_b_cnt > 0) slv_b_cnt--;
         else begin M_AXI_BVALID = 1'b1; M_AXI_BRESP = inj_resp; end
      end
      M_AXI_RVALID = 1'b0;
      M_AXI_RDATA  = $urandom;
      M_AXI_RRESP  = 2'($urandom_range(0, 3));
      if (slv_r_pend && !hold_r) begin
         if (slv_r_cnt > 0) slv_r_cnt--;
         else begin M_AXI_RVALID = 1'b1; M_AXI_RDATA = slv_rdata; M_AXI_RRESP = inj_resp; end
      end
      #1;
      // arbitration: next winner searched from one past the last grant
      exp_ready = '0;
      win = -1;
      if (!busy) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (last_grant + k) % N;
            if (win < 0 && pend[c]) win = c;
         end
      end
      if (win >= 0) exp_ready = N'(1) << win;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("awvalid", 32'(M_AXI_AWVALID), 32'(aw_exp));
      check("wvalid", 32'(M_AXI_WVALID), 32'(w_exp));
      check("arvalid", 32'(M_AXI_ARVALID), 32'(ar_exp));
      check("bready", 32'(M_AXI_BREADY), 32'(b_exp));
      check("rready", 32'(M_AXI_RREADY), 32'(r_exp));
      if (aw_exp) check("awaddr", 32'(M_AXI_AWADDR), 32'(cur_addr));
      if (w_exp) begin
         check("wdata", M_AXI_WDATA, cur_wdata);
         check("wstrb", 32'(M_AXI_WSTRB), 32'hF);
      end
      if (ar_exp) check("araddr", 32'(M_AXI_ARADDR), 32'(cur_addr));
      check("rsp_valid", 32'(rsp_valid), rsp_due ? (32'd1 << cur_idx) : 32'd0);
      if (rsp_due) begin
         exp_rd = cur_we ? last_rdata : cur_rdata_exp;
         check("rsp_resp", 32'(rsp_resp), 32'(cur_resp));
         check("rsp_rdata", rsp_rdata, exp_rd);
         if (lat_chk) check("rsp_latency", cyc - grant_cyc, 3);
         last_rdata = exp_rd;
         busy = 0;
         rsp_due = 0;
      end else begin
         check("rdata_hold", rsp_rdata, last_rdata);
      end
      aw_hs = aw_exp && M_AXI_AWREADY;
      w_hs  = w_exp && M_AXI_WREADY;
      ar_hs = ar_exp && M_AXI_ARREADY;
      b_hs  = b_exp && M_AXI_BVALID;
      r_hs  = r_exp && M_AXI_RVALID;
      if (aw_hs) begin aw_exp = 0; aw_done = 1; end
      if (w_hs)  begin w_exp = 0;  w_done = 1;  end
      if (aw_done && w_done) begin b_exp = 1; aw_done = 0; w_done = 0; end
      if (b_hs)  begin b_exp = 0; rsp_due = 1; end
      if (ar_hs) begin ar_exp = 0; r_exp = 1; end
      if (r_hs)  begin r_exp = 0; rsp_due = 1; end
      if (M_AXI_BVALID && M_AXI_BREADY) slv_b_pend = 0;
      if (M_AXI_RVALID && M_AXI_RREADY) slv_r_pend = 0;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin slv_aw = 1; slv_awaddr = M_AXI_AWADDR; end
      if (M_AXI_WVALID && M_AXI_WREADY) begin slv_w = 1; slv_wdata = M_AXI_WDATA; end
      if (slv_aw && slv_w) begin
         slv_aw = 0; slv_w = 0;
         if (inj_resp == RESP_OKAY) slv_mem[slv_awaddr[3:2]] = slv_wdata;
         slv_b_pend = 1; slv_b_cnt = pick_delay();
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
         slv_r_pend = 1; slv_r_cnt = pick_delay();
         slv_rdata = (inj_resp == RESP_OKAY) ? slv_mem[M_AXI_ARADDR[3:2]] : 32'hDEAD_BEEF;
      end
      if (win >= 0) begin
         pend[win] = 0; last_grant = win; busy = 1; grant_cyc = cyc; cur_idx = win;
         cur_we = op_we[win]; cur_addr = op_addr[win]; cur_wdata = op_wdata[win];
         inj_resp = ($urandom_range(0, 5) == 0) ?
                    (($urandom_range(0, 1) == 1) ? RESP_SLVERR : RESP_DECERR) : RESP_OKAY;
         cur_resp = inj_resp;
         if (cur_we) begin
            aw_exp = 1; w_exp = 1;
            if (cur_resp == RESP_OKAY) ref_mem[cur_addr[3:2]] = cur_wdata;
         end else begin
            ar_exp = 1;
            cur_rdata_exp = (cur_resp == RESP_OKAY) ? ref_mem[cur_addr[3:2]] : 32'hDEAD_BEEF;
         end
      end
   endtask

   task automatic drain();
      int guard = 0;
      issuing = 0;
      while ((busy || any_pend()) && guard < 400) begin
         step();
         guard++;
      end
      check("drain_done", 32'(busy || any_pend()), 32'd0);
   endtask

   task automatic run_phase(input int cycles, input int pct, input bit rnd, input int dly,
                            input bit drop, input bit lat);
      issuing = 1; req_pct = pct; rdy_random = rnd; delay_fix = dly;
      allow_drop = drop; lat_chk = lat;
      repeat (cycles) step();
      drain();
   endtask

   initial begin
      ARESET = 1'b1;
      req_valid = '1; req_we = '0; req_addr = '0; req_wdata = '0;
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
      M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
      cyc = 0; hold_r = 0;
      model_reset();
      repeat (2) @(negedge ACLK);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
      check("rst_wvalid", 32'(M_AXI_WVALID), 32'd0);
      check("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
      check("rst_bready", 32'(M_AXI_BREADY), 32'd0);
      check("rst_rready", 32'(M_AXI_RREADY), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_resp", 32'(rsp_resp), 32'd0);
      check("rst_awaddr", 32'(M_AXI_AWADDR), 32'd0);
      check("rst_wdata", M_AXI_WDATA, 32'd0);
      check("awprot", 32'(M_AXI_AWPROT), 32'd0);
      check("arprot", 32'(M_AXI_ARPROT), 32'd0);
      req_valid = '0;
      @(negedge ACLK);
      ARESET = 1'b0;

      run_phase(300, 30, 1'b0, 0, 1'b0, 1'b1);    // zero-wait slave, exact latency
      run_phase(1500, 40, 1'b1, -1, 1'b1, 1'b0);  // random ready/valid timing, drops
      run_phase(200, 100, 1'b0, 0, 1'b0, 1'b1);   // all requesters always valid
      run_phase(300, 60, 1'b0, 10, 1'b0, 1'b0);   // slow B/R responses

      // reset while the read waits in RD_RESP
      hold_r = 1; issuing = 0; rdy_random = 0; delay_fix = 0; lat_chk = 0; allow_drop = 0;
      pend[0] = 1; op_we[0] = 0; op_addr[0] = 4'h8;
      repeat (4) step();
      check("rready_before_reset", 32'(M_AXI_RREADY), 32'd1);
      #1 ARESET = 1'b1;
      req_valid = 3'b011;
      #1;
      check("mid_rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
      check("mid_rst_rready", 32'(M_AXI_RREADY), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_req_ready", 32'(req_ready), 32'd0);
      model_reset();
      req_valid = '0;
      M_AXI_RVALID = 1'b0;
      @(negedge ACLK);
      ARESET = 1'b0;
      hold_r = 0;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1; op_we[i] = 0; op_addr[i] = 4'h0;
      end
      step();
      check("first_grant_after_reset", 32'(req_ready), 32'd1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
